// File: rtl/hls_call_seq.sv
// hls_call_seq: queues call requests and replays each as the core's pc0/setb/idle entry protocol.
// Optional HLS_CALL_TIMEOUT_EN aborts a run after TIMEOUT cycles and flags it via done_err.
module hls_call_seq #(
  parameter int PC_W      = 9,
  parameter int XLEN      = 32,
  parameter int DEPTH     = 4,
  parameter int SETUP_CYC = 3,
  parameter int HOLD_CYC  = 3,
  parameter int TIMEOUT   = 65535
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     cmd_valid,
  output logic                     cmd_ready,
  input  logic [PC_W-1:0]          cmd_pc,
  input  logic [XLEN-1:0]          cmd_ra,
  input  logic [XLEN-1:0]          cmd_a0,
  input  logic [XLEN-1:0]          cmd_sp,
  output logic [PC_W-1:0]          pc0,
  output logic [XLEN-1:0]          ra0,
  output logic [XLEN-1:0]          a00,
  output logic [XLEN-1:0]          sp0,
  output logic                     setb,
  input  logic                     idle,
  output logic                     busy,
  output logic                     done,
  output logic                     done_err,
  output logic [$clog2(DEPTH):0]   level
);
  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;
  localparam int DW = PC_W + 3 * XLEN;
  localparam int PM = SETUP_CYC > HOLD_CYC ? SETUP_CYC : HOLD_CYC;
  localparam int CW = $clog2(PM + 1) + 1;
  localparam logic [2:0] S_IDLE = 3'd0, S_LOAD = 3'd1, S_RUN = 3'd2, S_HOLD = 3'd3, S_DONE = 3'd4;
  logic [DW-1:0] mem [DEPTH];
  logic [AW-1:0] wp, rp;
  logic [2:0] state, nxt;
  logic [CW-1:0] ph;
  logic push, pop, qual, tmo_hit;
  assign cmd_ready = level != LW'(DEPTH) && !rst;
  assign push = cmd_valid && cmd_ready;
  assign pop = state == S_IDLE && level != '0;
  // idle is only trusted once the core has had a cycle to leave its park state
  assign qual = idle && ph != '0;
  assign setb = state == S_RUN || state == S_HOLD;
  assign done = state == S_DONE;
  assign busy = state != S_IDLE || level != '0;
  always_comb
    nxt = state == S_IDLE ? (pop ? S_LOAD : S_IDLE) :
          state == S_LOAD ? (ph == CW'(SETUP_CYC) ? S_RUN : S_LOAD) :
          state == S_RUN  ? (qual || tmo_hit ? S_HOLD : S_RUN) :
          state == S_HOLD ? (ph == CW'(HOLD_CYC - 1) ? S_DONE : S_HOLD) : S_IDLE;
  always_ff @(posedge clk)
    if (push) mem[wp] <= {cmd_pc, cmd_ra, cmd_a0, cmd_sp};
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      wp <= '0;
      rp <= '0;
      level <= '0;
      state <= S_IDLE;
      ph <= '0;
      {pc0, ra0, a00, sp0} <= '0;
    end else begin
      wp <= push ? wp + AW'(1) : wp;
      rp <= pop ? rp + AW'(1) : rp;
      level <= level + LW'(push) - LW'(pop);
      state <= nxt;
      ph <= nxt != state ? '0 : state == S_RUN ? CW'(1) : ph + CW'(1);
      {pc0, ra0, a00, sp0} <= pop ? mem[rp] : {pc0, ra0, a00, sp0};
    end
`ifdef HLS_CALL_TIMEOUT_EN
  logic [31:0] tmo;
  logic err;
  assign tmo_hit = tmo == 32'(TIMEOUT);
  assign done_err = done && err;
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      tmo <= '0;
      err <= 1'b0;
    end else begin
      tmo <= state != S_RUN ? '0 : tmo + 32'd1;
      err <= state == S_LOAD ? 1'b0 : (state == S_RUN && !qual && tmo_hit) ? 1'b1 : err;
    end
`else
  assign tmo_hit = 1'b0;
  assign done_err = 1'b0;
`endif
endmodule

// File: tb/tb_hls_call_seq.sv
// tb_hls_call_seq: directed table plus multi-cycle sequences against a behavioural core model.
module tb_hls_call_seq;
`ifdef HLS_CALL_TIMEOUT_EN
  localparam int TMO = 100;
`else
  localparam int TMO = 65535;
`endif
  logic clk = 0, rst = 1;
  logic cmd_valid = 0, cmd_ready;
  logic [8:0] cmd_pc = 0, pc0;
  logic [31:0] cmd_ra = 0, cmd_a0 = 0, cmd_sp = 0, ra0, a00, sp0;
  logic setb, idle, busy, done, done_err;
  logic [2:0] level;
  always #5 clk = ~clk;

  hls_call_seq #(.PC_W(9), .XLEN(32), .DEPTH(4), .SETUP_CYC(3), .HOLD_CYC(3), .TIMEOUT(TMO)) dut (
    .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_pc(cmd_pc),
    .cmd_ra(cmd_ra), .cmd_a0(cmd_a0), .cmd_sp(cmd_sp), .pc0(pc0), .ra0(ra0), .a00(a00),
    .sp0(sp0), .setb(setb), .idle(idle), .busy(busy), .done(done), .done_err(done_err),
    .level(level));

  // core model: idle rises in setb-high cycle index idle_at (0 = idle held high always)
  int idle_at = 0;
  int sc = 0;
  always @(posedge clk) sc <= setb ? sc + 1 : 0;
  assign idle = sc >= idle_at;

  int done_cnt = 0, err_cnt = 0, hi_cnt = 0;
  logic pv = 0;
  logic [8:0] pc_log[$];
  int ram[75];
  int wr_i = 0, rd_i = 0;
  int popped[$];

  function automatic void sort_ram(int n);
    for (int i = 1; i < n; i++) begin
      int v = ram[i];
      int j = i - 1;
      while (j >= 0 && ram[j] > v) begin
        ram[j+1] = ram[j];
        j--;
      end
      ram[j+1] = v;
    end
  endfunction

  always @(negedge clk) begin
    if (setb && !pv) begin
      pc_log.push_back(pc0);
      if (pc0 == 9'h0a0 && wr_i < 75) begin
        ram[wr_i] = int'(a00);
        wr_i++;
      end else if (pc0 == 9'h16c) sort_ram(wr_i);
      else if (pc0 == 9'h0d0 && rd_i < wr_i) begin
        popped.push_back(ram[rd_i]);
        rd_i++;
      end
    end
    pv = setb;
    if (setb) hi_cnt++;
    if (done) begin
      done_cnt++;
      if (done_err) err_cnt++;
    end
  end

  int pass_n = 0, tot = 0;
  task automatic chk(string nm, logic [127:0] act, logic [127:0] exp);
    tot++;
    if (act === exp) pass_n++;
    else $display("FAIL %s: got %0h want %0h", nm, act, exp);
  endtask
  task automatic fail(string nm);
    tot++;
    $display("FAIL %s: bound expired", nm);
  endtask
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic push(logic [8:0] pc, logic [31:0] ra, logic [31:0] a0, logic [31:0] sp);
    int n = 0;
    cmd_pc = pc; cmd_ra = ra; cmd_a0 = a0; cmd_sp = sp; cmd_valid = 1;
    while (!cmd_ready && n < 500) begin tick; n++; end
    if (n == 500) fail("push_wait");
    tick;
    cmd_valid = 0;
  endtask
  task automatic wait_quiet;
    int n = 0;
    while (busy && n < 3000) begin tick; n++; end
    if (n == 3000) fail("quiet_wait");
    tick;
  endtask
  task automatic wait_setb;
    int n = 0;
    while (!setb && n < 100) begin tick; n++; end
    if (n == 100) fail("setb_wait");
  endtask

  typedef struct {
    logic [8:0] pc;
    logic [31:0] ra, a0, sp;
    int idle_at;
    int len;
  } row_t;
  row_t rows[5];

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit");
    $fatal(1);
  end

  initial begin
    int d0, e0, h0, k, base, bad;
    rows[0] = '{9'h000, 32'h44, 32'h1000, 32'h1ffc, 19, 23};
    rows[1] = '{9'h0f3, 32'h80, 32'hdead_beef, 32'h2000, 0, 5};
    rows[2] = '{9'h1ff, 32'hffff_ffff, 32'h0, 32'h1, 1, 5};
    rows[3] = '{9'h155, 32'haaaa_5555, 32'h1234_5678, 32'h3ff0, 2, 6};
    rows[4] = '{9'h0aa, 32'h5555_aaaa, 32'h8765_4321, 32'h0ff8, 5, 9};
    #1;
    chk("rst_ready", cmd_ready, 0);
    chk("rst_outs", {setb, done, done_err, busy, level}, 0);
    chk("rst_ops", {pc0, ra0, a00, sp0}, 0);
    repeat (3) @(negedge clk);
    rst = 0;
    tick;
    chk("ready_after_rst", cmd_ready, 1);

    // T1/T3 single calls from a table
    foreach (rows[r]) begin
      wait_quiet;
      d0 = done_cnt; e0 = err_cnt;
      idle_at = rows[r].idle_at;
      push(rows[r].pc, rows[r].ra, rows[r].a0, rows[r].sp);
      tick; tick;
      chk($sformatf("r%0d_setup_low", r), setb, 0);
      chk($sformatf("r%0d_setup_ops", r), {pc0, ra0, a00, sp0},
          {rows[r].pc, rows[r].ra, rows[r].a0, rows[r].sp});
      k = 2;
      while (!setb && k < 50) begin tick; k++; end
      chk($sformatf("r%0d_latency", r), k, 5);
      chk($sformatf("r%0d_run_ops", r), {pc0, ra0, a00, sp0},
          {rows[r].pc, rows[r].ra, rows[r].a0, rows[r].sp});
      k = 0;
      while (setb && k < 200) begin tick; k++; end
      chk($sformatf("r%0d_setb_len", r), k, rows[r].len);
      wait_quiet;
      chk($sformatf("r%0d_done", r), done_cnt - d0, 1);
      chk($sformatf("r%0d_err", r), err_cnt - e0, 0);
    end

    // T3 continuous idle over back-to-back calls
    idle_at = 0; d0 = done_cnt; h0 = hi_cnt;
    for (int i = 0; i < 3; i++) push(9'h0e0 + 9'(i), 0, 0, 0);
    wait_quiet;
    chk("t3_done", done_cnt - d0, 3);
    chk("t3_setb_total", hi_cnt - h0, 15);

    // T2 FIFO full and ordering
    idle_at = 10; d0 = done_cnt; base = pc_log.size();
    push(9'h101, 1, 1, 1);
    tick; tick;
    for (int i = 0; i < 4; i++) push(9'h102 + 9'(i), 2, 2, 2);
    chk("t2_level", level, 4);
    chk("t2_ready", cmd_ready, 0);
    push(9'h106, 3, 3, 3);
    wait_quiet;
    chk("t2_done", done_cnt - d0, 6);
    chk("t2_calls", pc_log.size() - base, 6);
    bad = 0;
    for (int i = 0; i < 6; i++)
      if (base + i >= pc_log.size() || pc_log[base+i] != 9'h101 + 9'(i)) bad++;
    chk("t2_order", bad, 0);

    // T4 reset mid-call with two queued
    idle_at = 1000;
    push(9'h1a0, 0, 0, 0); push(9'h1a1, 0, 0, 0); push(9'h1a2, 0, 0, 0);
    wait_setb;
    tick;
    chk("t4_queued", level, 2);
    d0 = done_cnt;
    #2 rst = 1;
    #1;
    chk("t4_async_setb", setb, 0);
    chk("t4_async_level", {cmd_ready, level}, 0);
    @(negedge clk) rst = 0;
    repeat (20) tick;
    chk("t4_idle", {busy, level}, 0);
    chk("t4_no_done", done_cnt - d0, 0);

`ifdef HLS_CALL_TIMEOUT_EN
    // T5 timeout then a normal call
    idle_at = 1000000; d0 = done_cnt; e0 = err_cnt;
    push(9'h1b0, 0, 0, 0); push(9'h1b1, 0, 0, 0);
    wait_setb;
    k = 0;
    while (!done && k < 300) begin tick; k++; end
    chk("t5_timeout_lat", k, 104);
    chk("t5_done_err", done_err, 1);
    idle_at = 3;
    wait_quiet;
    chk("t5_done", done_cnt - d0, 2);
    chk("t5_err_once", err_cnt - e0, 1);
`endif

    // T6 end-to-end push/sort/pop
    idle_at = 2; d0 = done_cnt;
    for (int i = 0; i < 75; i++) push(9'h0a0, 0, 32'($urandom_range(0, 9999)), 32'h1000);
    push(9'h16c, 32'h1f8, 0, 32'h1000);
    for (int i = 0; i < 75; i++) push(9'h0d0, 0, 0, 32'h1000);
    wait_quiet;
    chk("t6_done", done_cnt - d0, 151);
    chk("t6_popped", popped.size(), 75);
    bad = 0;
    for (int i = 1; i < popped.size(); i++) if (popped[i] < popped[i-1]) bad++;
    chk("t6_sorted", bad, 0);

    $display("%0d/%0d checks passed", pass_n, tot);
    $finish;
  end
endmodule
